// File: rtl/proj001_arbiter.sv
// ---------------------------------------------------------------------------
// proj001_arbiter
//
// Round-robin scheduler that shares one proj001 compute engine between NREQ
// requesters. On a grant it latches the requester's operand slice and streams
// the OPS words into the engine as a burst framed by eng_start on the first
// word. It then waits for the engine's valid pulse, guarded by a watchdog, and
// hands the result back to the granted requester with a one-cycle ack.
//
// Ports
//   clock       in   1               system clock, rising edge
//   rst_n       in   1               asynchronous active-low reset
//   req         in   NREQ            req[i] held high until ack[i]
//   req_data    in   NREQ*OPS*WIDTH  requester i at [i*OPS*WIDTH +: OPS*WIDTH],
//                                    word 0 in the LSBs
//   ack         out  NREQ            one-cycle, one-hot completion pulse
//   rsp_result  out  WIDTH+1         result, valid while ack is non-zero
//   rsp_err     out  1               watchdog timeout flag, valid with ack
//   busy        out  1               high whenever the FSM is not idle
//   eng_start   out  1               engine start, high with word 0
//   eng_d_in    out  WIDTH           engine operand word
//   eng_result  in   WIDTH+1         engine result
//   eng_valid   in   1               engine result valid pulse
// ---------------------------------------------------------------------------
module proj001_arbiter #(
  parameter int WIDTH   = 4,
  parameter int NREQ    = 4,
  parameter int OPS     = 2,
  parameter int TIMEOUT = 32
) (
  input  logic                      clock,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*OPS*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]           ack,
  output logic [WIDTH:0]            rsp_result,
  output logic                      rsp_err,
  output logic                      busy,
  output logic                      eng_start,
  output logic [WIDTH-1:0]          eng_d_in,
  input  logic [WIDTH:0]            eng_result,
  input  logic                      eng_valid
);

  localparam int PTR_W   = $clog2(NREQ);
  localparam int WDOG_W  = $clog2(TIMEOUT);
  localparam int K_W     = (OPS > 1) ? $clog2(OPS) : 1;
  localparam int SLICE_W = OPS * WIDTH;

  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(NREQ - 1);
  localparam logic [WDOG_W-1:0] LAST_WDOG = WDOG_W'(TIMEOUT - 1);
  localparam logic [K_W-1:0]    LAST_K    = K_W'(OPS - 1);
  localparam logic [NREQ-1:0]   ACK_ONE   = NREQ'(1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t              state;
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    grant_q;
  logic [SLICE_W-1:0]  ops_q;
  logic [K_W-1:0]      k;
  logic [WDOG_W-1:0]   wdog;

  logic                grant_valid;
  logic [PTR_W-1:0]    grant_idx;
  logic [SLICE_W-1:0]  grant_slice;

  // Round-robin pick: scan from rr_ptr upward with wrap, first set bit wins.
  always_comb begin
    int cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int j = 0; j < NREQ; j++) begin
      cand = int'(rr_ptr) + j;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = PTR_W'(cand);
      end
    end
    grant_slice = req_data[int'(grant_idx)*SLICE_W +: SLICE_W];
  end

  // Main FSM. Word 0 goes straight onto eng_d_in at grant so that eng_start
  // and the first operand appear in the cycle after the request is seen; the
  // remaining words sit in ops_q and are shifted down one word per cycle.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant_q    <= '0;
      ops_q      <= '0;
      k          <= '0;
      wdog       <= '0;
      ack        <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
      eng_start  <= 1'b0;
      eng_d_in   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            grant_q   <= grant_idx;
            ops_q     <= grant_slice >> WIDTH;
            eng_d_in  <= grant_slice[WIDTH-1:0];
            eng_start <= 1'b1;
            k         <= '0;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end

        ISSUE: begin
          eng_start <= 1'b0;
          if (k == LAST_K) begin
            eng_d_in <= '0;
            wdog     <= '0;
            state    <= WAIT;
          end else begin
            eng_d_in <= ops_q[WIDTH-1:0];
            ops_q    <= ops_q >> WIDTH;
            k        <= k + 1'b1;
          end
        end

        // A valid result takes priority over a watchdog expiry on the same edge.
        WAIT: begin
          if (eng_valid) begin
            rsp_result <= eng_result;
            rsp_err    <= 1'b0;
            ack        <= ACK_ONE << grant_q;
            state      <= RESP;
          end else if (wdog == LAST_WDOG) begin
            rsp_result <= '0;
            rsp_err    <= 1'b1;
            ack        <= ACK_ONE << grant_q;
            state      <= RESP;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end

        RESP: begin
          ack        <= '0;
          rsp_result <= '0;
          rsp_err    <= 1'b0;
          busy       <= 1'b0;
          rr_ptr     <= (grant_q == LAST_PTR) ? '0 : grant_q + 1'b1;
          state      <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_proj001_arbiter.sv
// ---------------------------------------------------------------------------
// tb_proj001_arbiter
//
// Self-checking bench for proj001_arbiter (WIDTH=4, NREQ=4, OPS=2,
// TIMEOUT=32). A small engine model sums the operand words it receives and
// answers three cycles after start. A transaction-level reference model,
// updated on every rising edge, predicts all DUT outputs from the arbitration
// rules; every falling edge compares them. Directed scenarios add literal
// expectations for grant order, latency, results and reset behaviour.
// ---------------------------------------------------------------------------
module tb_proj001_arbiter;

  localparam int WIDTH   = 4;
  localparam int NREQ    = 4;
  localparam int OPS     = 2;
  localparam int TIMEOUT = 32;

  logic                      clock = 1'b0;
  logic                      rst_n;
  logic [NREQ-1:0]           req;
  logic [NREQ*OPS*WIDTH-1:0] req_data;
  logic [NREQ-1:0]           ack;
  logic [WIDTH:0]            rsp_result;
  logic                      rsp_err;
  logic                      busy;
  logic                      eng_start;
  logic [WIDTH-1:0]          eng_d_in;
  logic [WIDTH:0]            eng_result;
  logic                      eng_valid;

  int checks = 0;
  int errors = 0;

  // Engine controls, written only by the main stimulus process.
  bit eng_silent = 1'b0;
  int stray_req  = 0;

  // Reference model predictions for the cycle following each rising edge.
  logic [NREQ-1:0]  x_ack    = '0;
  logic [WIDTH:0]   x_result = '0;
  logic             x_err    = 1'b0;
  logic             x_busy   = 1'b0;
  logic             x_start  = 1'b0;
  logic [WIDTH-1:0] x_din    = '0;

  logic [NREQ-1:0] got;
  int              cyc;
  int              idle;

  proj001_arbiter #(
    .WIDTH  (WIDTH),
    .NREQ   (NREQ),
    .OPS    (OPS),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .rsp_result(rsp_result),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .eng_start (eng_start),
    .eng_d_in  (eng_d_in),
    .eng_result(eng_result),
    .eng_valid (eng_valid)
  );

  always #5 clock = ~clock;

  // Engine model: sums the burst words, pulses valid three cycles after the
  // start cycle unless silenced, and can inject one stray valid on request.
  initial begin
    logic [WIDTH:0] acc;
    int             cnt;
    int             idx;
    int             stray_done;
    acc        = '0;
    cnt        = 0;
    idx        = OPS;
    stray_done = 0;
    eng_valid  = 1'b0;
    eng_result = '0;
    forever begin
      @(negedge clock);
      eng_valid  = 1'b0;
      eng_result = acc;
      if (!rst_n) begin
        cnt = 0;
        idx = OPS;
      end else begin
        if (eng_start) begin
          acc = {1'b0, eng_d_in};
          idx = 1;
          cnt = 3;
        end else begin
          if (idx < OPS) begin
            acc = acc + {1'b0, eng_d_in};
            idx++;
          end
          if (cnt > 0) begin
            cnt--;
            if (cnt == 0 && !eng_silent) begin
              eng_valid  = 1'b1;
              eng_result = acc;
            end
          end
        end
        if (stray_req != stray_done) begin
          stray_done = stray_req;
          eng_valid  = 1'b1;
          eng_result = 5'h1F;
        end
      end
    end
  end

  // Reference model. Tracks one transaction by its grant edge number and
  // derives every output from the offset since that grant.
  initial begin
    int               edge_no;
    bit               m_active;
    bit               m_resp;
    int               m_e0;
    int               m_g;
    int               m_ptr;
    int               off;
    int               cand;
    bit               found;
    logic [WIDTH-1:0] m_words [OPS];
    logic [WIDTH:0]   m_res;
    bit               m_err;
    edge_no  = 0;
    m_active = 1'b0;
    m_resp   = 1'b0;
    m_e0     = 0;
    m_g      = 0;
    m_ptr    = 0;
    m_res    = '0;
    m_err    = 1'b0;
    for (int w = 0; w < OPS; w++) m_words[w] = '0;
    forever begin
      @(posedge clock);
      edge_no++;
      if (!rst_n) begin
        m_active = 1'b0;
        m_resp   = 1'b0;
        m_ptr    = 0;
      end else if (m_resp) begin
        m_resp   = 1'b0;
        m_active = 1'b0;
        m_ptr    = (m_g + 1) % NREQ;
      end else if (m_active) begin
        off = edge_no - m_e0;
        if (off >= OPS + 1) begin
          if (eng_valid) begin
            m_resp = 1'b1;
            m_res  = eng_result;
            m_err  = 1'b0;
          end else if (off == OPS + TIMEOUT) begin
            m_resp = 1'b1;
            m_res  = '0;
            m_err  = 1'b1;
          end
        end
      end else if (req != '0) begin
        found = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
          cand = (m_ptr + j) % NREQ;
          if (!found && req[cand]) begin
            found = 1'b1;
            m_g   = cand;
          end
        end
        for (int w = 0; w < OPS; w++)
          m_words[w] = req_data[(m_g*OPS + w)*WIDTH +: WIDTH];
        m_active = 1'b1;
        m_e0     = edge_no;
      end

      x_ack    = '0;
      x_result = '0;
      x_err    = 1'b0;
      x_busy   = m_active;
      x_start  = 1'b0;
      x_din    = '0;
      if (m_active) begin
        if (m_resp) begin
          x_ack[m_g] = 1'b1;
          x_result   = m_res;
          x_err      = m_err;
        end else begin
          off = edge_no - m_e0;
          if (off < OPS) begin
            x_din   = m_words[off];
            x_start = (off == 0);
          end
        end
      end
    end
  end

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: compare every output with the model on the falling edge,
  // then let any requester that sees its ack drop its request.
  task automatic checkOutput();
    @(negedge clock);
    checkValue("ack",        32'(ack),        32'(x_ack));
    checkValue("rsp_result", 32'(rsp_result), 32'(x_result));
    checkValue("rsp_err",    32'(rsp_err),    32'(x_err));
    checkValue("busy",       32'(busy),       32'(x_busy));
    checkValue("eng_start",  32'(eng_start),  32'(x_start));
    checkValue("eng_d_in",   32'(eng_d_in),   32'(x_din));
    checkValue("ack_onehot", 32'($onehot0(ack)), 32'(1));
    req = req & ~ack;
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] set_bits);
    req = req | set_bits;
  endtask

  task automatic setWords(input int i, input logic [WIDTH-1:0] w0, input logic [WIDTH-1:0] w1);
    req_data[(i*OPS)*WIDTH +: WIDTH]     = w0;
    req_data[(i*OPS + 1)*WIDTH +: WIDTH] = w1;
  endtask

  task automatic waitAck(input int limit, output logic [NREQ-1:0] ack_seen,
                         output int cycles, output int idle_cycles);
    ack_seen    = '0;
    cycles      = 0;
    idle_cycles = 0;
    while (ack_seen == '0 && cycles < limit) begin
      checkOutput();
      cycles++;
      if (!busy) idle_cycles++;
      ack_seen = ack;
    end
    if (ack_seen == '0) begin
      checks++;
      errors++;
      $display("[TB] FAIL ack_wait: got no ack within %0d cycles, expected an ack", limit);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    rst_n    = 1'b0;
    req      = 4'b0010;
    req_data = '0;
    setWords(1, 4'h1, 4'h2);

    // Reset held with a pending request: nothing moves until release.
    $display("[TB] reset with pending request");
    repeat (3) checkOutput();
    checkValue("t1_rst_busy",  32'(busy),      32'(0));
    checkValue("t1_rst_start", 32'(eng_start), 32'(0));
    checkValue("t1_rst_ack",   32'(ack),       32'(0));
    rst_n = 1'b1;
    waitAck(20, got, cyc, idle);
    checkValue("t1_ack",    32'(got),        32'(4'b0010));
    checkValue("t1_result", 32'(rsp_result), 32'(5'h03));
    checkOutput();

    // Single request, two words, result and latency.
    $display("[TB] single request to requester 2");
    setWords(2, 4'h9, 4'h3);
    applyStimulus(4'b0100);
    checkOutput();
    checkValue("t2_start_w0", 32'(eng_start), 32'(1));
    checkValue("t2_word0",    32'(eng_d_in),  32'(4'h9));
    setWords(2, 4'hF, 4'hF);
    checkOutput();
    checkValue("t2_start_w1", 32'(eng_start), 32'(0));
    checkValue("t2_word1",    32'(eng_d_in),  32'(4'h3));
    waitAck(20, got, cyc, idle);
    checkValue("t2_ack",     32'(got),        32'(4'b0100));
    checkValue("t2_result",  32'(rsp_result), 32'(5'h0C));
    checkValue("t2_err",     32'(rsp_err),    32'(0));
    checkValue("t2_latency", 32'(cyc + 2),    32'(5));
    checkOutput();

    // Pointer sits at 3: requester 3 wins over 0, then 0 follows.
    $display("[TB] round-robin wrap from pointer 3");
    setWords(3, 4'h4, 4'h4);
    setWords(0, 4'h7, 4'h1);
    applyStimulus(4'b1001);
    waitAck(20, got, cyc, idle);
    checkValue("t4_first",  32'(got), 32'(4'b1000));
    waitAck(20, got, cyc, idle);
    checkValue("t4_second", 32'(got), 32'(4'b0001));
    checkValue("t4_result", 32'(rsp_result), 32'(5'h08));
    checkOutput();

    // Silent engine: watchdog fires after 32 WAIT cycles.
    $display("[TB] watchdog timeout");
    eng_silent = 1'b1;
    setWords(3, 4'h2, 4'h2);
    applyStimulus(4'b1000);
    waitAck(60, got, cyc, idle);
    checkValue("t5_ack",     32'(got),        32'(4'b1000));
    checkValue("t5_err",     32'(rsp_err),    32'(1));
    checkValue("t5_result",  32'(rsp_result), 32'(0));
    checkValue("t5_latency", 32'(cyc),        32'(OPS + TIMEOUT + 1));
    checkOutput();
    eng_silent = 1'b0;
    setWords(0, 4'h5, 4'h5);
    applyStimulus(4'b0001);
    waitAck(20, got, cyc, idle);
    checkValue("t5n_ack",     32'(got),        32'(4'b0001));
    checkValue("t5n_err",     32'(rsp_err),    32'(0));
    checkValue("t5n_result",  32'(rsp_result), 32'(5'h0A));
    checkValue("t5n_latency", 32'(cyc),        32'(5));
    checkOutput();

    // Reset during WAIT aborts the transaction without an ack.
    $display("[TB] reset during WAIT");
    setWords(1, 4'h3, 4'h3);
    applyStimulus(4'b0010);
    repeat (3) checkOutput();
    checkValue("t6_busy_in_wait", 32'(busy), 32'(1));
    rst_n  = 1'b0;
    req[1] = 1'b0;
    checkOutput();
    checkValue("t6_rst_busy", 32'(busy), 32'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput();
      checkValue("t6_no_ack",  32'(ack),  32'(0));
      checkValue("t6_idle",    32'(busy), 32'(0));
    end

    // All four requesting from pointer 0: fair order, one idle cycle between.
    $display("[TB] all requesters contending");
    setWords(0, 4'h1, 4'h1);
    setWords(1, 4'h2, 4'h2);
    setWords(2, 4'h3, 4'h3);
    setWords(3, 4'h4, 4'h4);
    applyStimulus(4'b1111);
    for (int k = 0; k < NREQ; k++) begin
      waitAck(20, got, cyc, idle);
      checkValue("t3_order", 32'(got), 32'(1) << k);
      if (k > 0) checkValue("t3_gap", 32'(idle), 32'(1));
    end
    checkOutput();

    // Stray engine valid during ISSUE is ignored; the real result arrives.
    $display("[TB] stray engine valid during ISSUE");
    setWords(2, 4'h5, 4'h6);
    applyStimulus(4'b0100);
    checkOutput();
    stray_req++;
    waitAck(20, got, cyc, idle);
    checkValue("t6s_ack",     32'(got),        32'(4'b0100));
    checkValue("t6s_result",  32'(rsp_result), 32'(5'h0B));
    checkValue("t6s_err",     32'(rsp_err),    32'(0));
    checkValue("t6s_latency", 32'(cyc + 1),    32'(5));
    repeat (2) checkOutput();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
